// File: rtl/bisr_pkg.sv
// Shared state type and width/ordering helpers for the BISR proxy select controllers.
// Downstream word muxes import the same spare-base rule so lane ordering always agrees.
package bisr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_ALLOCATE,
    ST_DONE,
    ST_FAIL
  } state_e;

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int lane_w(input int num_lanes);
    return idx_w(num_lanes);
  endfunction

  function automatic int sel_w(input int num_lanes, input int num_spares);
    return idx_w(num_lanes + num_spares);
  endfunction

  // Spare lanes occupy the mux inputs directly after the primaries.
  function automatic int spare_base(input int num_lanes);
    return num_lanes;
  endfunction

endpackage

// File: rtl/bisr_remap_table.sv
// Per-lane remap register file: synchronous clear, single write port, combinational read.
module bisr_remap_table #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 3,
  parameter int IDX_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ridx,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (rst || clr) begin
          mem_q[gi] <= '0;
        end else if (we && (int'(widx) == gi)) begin
          mem_q[gi] <= wdata;
        end
      end
    end
  endgenerate

  assign rdata = mem_q[ridx];

endmodule

// File: rtl/bisr_proxy_sel_ctrl.sv
// Collects BIST lane faults, assigns spare lanes one lane per cycle and answers
// lane lookups with a registered select for the downstream weight-proxy word mux.
module bisr_proxy_sel_ctrl
  import bisr_pkg::*;
#(
  parameter  int NUM_LANES  = 4,
  parameter  int NUM_SPARES = 2,
  localparam int LANE_W     = lane_w(NUM_LANES),
  localparam int SEL_W      = sel_w(NUM_LANES, NUM_SPARES),
  localparam int CNT_W      = idx_w(NUM_SPARES + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_repair,
  input  logic                 fault_valid,
  input  logic [LANE_W-1:0]    fault_lane,
  input  logic                 collect_done,
  output logic                 busy,
  output logic                 repair_done,
  output logic                 repair_fail,
  output logic [CNT_W-1:0]     spares_used,
  output logic [NUM_LANES-1:0] fault_map,
  input  logic                 lookup_valid,
  input  logic [LANE_W-1:0]    lookup_lane,
  output logic                 sel_valid,
  output logic [SEL_W-1:0]     out_sel,
  output logic                 lookup_err
);

  state_e               state_q, state_d;
  logic [NUM_LANES-1:0] fault_map_q, fault_map_d;
  logic [CNT_W-1:0]     ptr_q, ptr_d;
  logic [LANE_W-1:0]    scan_q, scan_d;
  logic                 fail_q, fail_d;
  logic                 lane_fail;
  logic                 tbl_clr, tbl_we;
  logic [SEL_W-1:0]     tbl_wdata, tbl_rdata;
  logic                 sel_valid_q, lookup_err_q, lookup_err_d;
  logic [SEL_W-1:0]     out_sel_q, out_sel_d;
  logic                 fault_in_range, lookup_in_range, scan_last;

  assign fault_in_range  = int'(fault_lane) < NUM_LANES;
  assign lookup_in_range = int'(lookup_lane) < NUM_LANES;
  assign scan_last       = int'(scan_q) == (NUM_LANES - 1);

  bisr_remap_table #(
    .DEPTH  (NUM_LANES),
    .DATA_W (SEL_W),
    .IDX_W  (LANE_W)
  ) u_remap (
    .clk   (clk),
    .rst   (rst),
    .clr   (tbl_clr),
    .we    (tbl_we),
    .widx  (scan_q),
    .wdata (tbl_wdata),
    .ridx  (lookup_lane),
    .rdata (tbl_rdata)
  );

  always_comb begin
    state_d     = state_q;
    fault_map_d = fault_map_q;
    ptr_d       = ptr_q;
    scan_d      = scan_q;
    fail_d      = fail_q;
    lane_fail   = 1'b0;
    tbl_clr     = 1'b0;
    tbl_we      = 1'b0;
    tbl_wdata   = SEL_W'(spare_base(NUM_LANES) + int'(ptr_q));
    if (start_repair) begin
      // Restart from any state; an in-flight allocation is abandoned.
      state_d     = ST_COLLECT;
      fault_map_d = '0;
      ptr_d       = '0;
      scan_d      = '0;
      fail_d      = 1'b0;
      tbl_clr     = 1'b1;
    end else begin
      case (state_q)
        ST_COLLECT: begin
          if (fault_valid && fault_in_range) begin
            fault_map_d[fault_lane] = 1'b1;
          end
          if (collect_done) begin
            state_d = ST_ALLOCATE;
            scan_d  = '0;
          end
        end
        ST_ALLOCATE: begin
          if (fault_map_q[scan_q]) begin
            if (int'(ptr_q) < NUM_SPARES) begin
              tbl_we = 1'b1;
              ptr_d  = ptr_q + CNT_W'(1);
            end else begin
              lane_fail = 1'b1;
              fail_d    = 1'b1;
            end
          end
          // The scan always visits every lane so the fail decision sees them all.
          if (scan_last) begin
            state_d = (fail_q || lane_fail) ? ST_FAIL : ST_DONE;
          end else begin
            scan_d = scan_q + LANE_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    out_sel_d    = out_sel_q;
    lookup_err_d = 1'b0;
    if (lookup_valid) begin
      if (!lookup_in_range) begin
        out_sel_d    = '0;
        lookup_err_d = 1'b1;
      end else if ((state_q == ST_DONE) && fault_map_q[lookup_lane]) begin
        out_sel_d = tbl_rdata;
      end else begin
        out_sel_d = SEL_W'(lookup_lane);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      fault_map_q  <= '0;
      ptr_q        <= '0;
      scan_q       <= '0;
      fail_q       <= 1'b0;
      sel_valid_q  <= 1'b0;
      out_sel_q    <= '0;
      lookup_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fault_map_q  <= fault_map_d;
      ptr_q        <= ptr_d;
      scan_q       <= scan_d;
      fail_q       <= fail_d;
      sel_valid_q  <= lookup_valid;
      out_sel_q    <= out_sel_d;
      lookup_err_q <= lookup_err_d;
    end
  end

  assign busy        = (state_q == ST_COLLECT) || (state_q == ST_ALLOCATE);
  assign repair_done = state_q == ST_DONE;
  assign repair_fail = state_q == ST_FAIL;
  assign spares_used = ptr_q;
  assign fault_map   = fault_map_q;
  assign sel_valid   = sel_valid_q;
  assign out_sel     = out_sel_q;
  assign lookup_err  = lookup_err_q;

endmodule

// File: tb/tb_bisr_proxy_sel_ctrl.sv
// Directed plus randomized bench for bisr_proxy_sel_ctrl against a set/rank reference model.
module tb_bisr_proxy_sel_ctrl;

  logic       clk = 1'b0;
  logic       rst, start_repair, fault_valid, collect_done, lookup_valid;
  logic [1:0] fault_lane, lookup_lane;
  logic       busy, repair_done, repair_fail, sel_valid, lookup_err;
  logic [1:0] spares_used;
  logic [3:0] fault_map;
  logic [2:0] out_sel;

  int checks = 0;
  int errors = 0;

  // Reference model: set of faulty lanes and the repair verdict.
  bit [3:0] m_faults;
  bit       m_done;
  bit       m_fail;
  int       m_used;
  int       rep_q[$];

  always #5 clk = ~clk;

  bisr_proxy_sel_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start_repair (start_repair),
    .fault_valid  (fault_valid),
    .fault_lane   (fault_lane),
    .collect_done (collect_done),
    .busy         (busy),
    .repair_done  (repair_done),
    .repair_fail  (repair_fail),
    .spares_used  (spares_used),
    .fault_map    (fault_map),
    .lookup_valid (lookup_valid),
    .lookup_lane  (lookup_lane),
    .sel_valid    (sel_valid),
    .out_sel      (out_sel),
    .lookup_err   (lookup_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // The k-th faulty lane in ascending order takes spare k, but only after a clean repair.
  function automatic int exp_sel(input int lane);
    int rank;
    rank = 0;
    if (m_done && m_faults[lane]) begin
      for (int j = 0; j < lane; j++) if (m_faults[j]) rank++;
      return 4 + rank;
    end
    return lane;
  endfunction

  task automatic model_clear();
    m_faults = '0;
    m_done   = 1'b0;
    m_fail   = 1'b0;
    m_used   = 0;
  endtask

  // Pulse start_repair, send rep_q as reports, then collect_done; returns in the first ALLOCATE cycle.
  task automatic collect(input bit merge_last);
    int cnt;
    start_repair = 1'b1;
    tick();
    start_repair = 1'b0;
    model_clear();
    check("clr_busy", busy, 1);
    check("clr_map", fault_map, 0);
    check("clr_used", spares_used, 0);
    check("clr_done", repair_done, 0);
    for (int i = 0; i < rep_q.size(); i++) begin
      fault_valid  = 1'b1;
      fault_lane   = 2'(rep_q[i]);
      m_faults[rep_q[i]] = 1'b1;
      collect_done = merge_last && (i == rep_q.size() - 1);
      tick();
    end
    if (!(merge_last && rep_q.size() > 0)) begin
      fault_valid  = 1'b0;
      collect_done = 1'b1;
      tick();
    end
    fault_valid  = 1'b0;
    collect_done = 1'b0;
    cnt = $countones(m_faults);
    m_fail = cnt > 2;
    m_used = m_fail ? 2 : cnt;
    m_done = !m_fail;
  endtask

  task automatic finish_alloc();
    for (int c = 0; c < 4; c++) begin
      check("alloc_busy", busy, 1);
      tick();
    end
    check("end_busy", busy, 0);
    check("end_done", repair_done, m_done);
    check("end_fail", repair_fail, m_fail);
    check("end_used", spares_used, m_used);
    check("end_map", fault_map, m_faults);
    $display("repair faults=%b done=%0b fail=%0b used=%0d", m_faults, m_done, m_fail, m_used);
  endtask

  task automatic lookup_one(input int lane);
    lookup_valid = 1'b1;
    lookup_lane  = 2'(lane);
    tick();
    lookup_valid = 1'b0;
    check("lk_valid", sel_valid, 1);
    check("lk_sel", out_sel, exp_sel(lane));
    check("lk_err", lookup_err, 0);
    $display("lookup lane=%0d sel=%0d expect=%0d", lane, out_sel, exp_sel(lane));
  endtask

  task automatic lookup_all();
    for (int l = 0; l < 4; l++) lookup_one(l);
  endtask

  initial begin
    rst = 1'b1; start_repair = 1'b0; fault_valid = 1'b0; collect_done = 1'b0;
    lookup_valid = 1'b0; fault_lane = '0; lookup_lane = '0;
    model_clear();
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", repair_done, 0);
    check("rst_fail", repair_fail, 0);
    check("rst_used", spares_used, 0);
    check("rst_map", fault_map, 0);
    check("rst_selv", sel_valid, 0);
    check("rst_sel", out_sel, 0);
    check("rst_err", lookup_err, 0);

    // Identity lookup in IDLE, then out_sel holds while sel_valid drops.
    lookup_one(2);
    check("idle_sel2", out_sel, 2);
    check("idle_busy", busy, 0);
    tick();
    check("hold_valid", sel_valid, 0);
    check("hold_sel", out_sel, 2);

    // Two faults, both repaired.
    rep_q = '{1, 3};
    collect(1'b0);
    finish_alloc();
    check("tp2_map", fault_map, 4'b1010);
    lookup_one(1);
    check("tp2_lane1", out_sel, 4);
    lookup_one(3);
    check("tp2_lane3", out_sel, 5);
    lookup_one(0);

    // Three faults exceed the spares: bypass.
    rep_q = '{0, 2, 3};
    collect(1'b0);
    finish_alloc();
    check("tp3_fail", repair_fail, 1);
    lookup_all();

    // Duplicate reports plus a fault coincident with collect_done.
    rep_q = '{2, 2, 1};
    collect(1'b1);
    finish_alloc();
    check("tp4_map", fault_map, 4'b0110);
    lookup_all();

    // Restart mid-allocation, then an empty collection.
    rep_q = '{1, 3};
    collect(1'b0);
    tick();
    tick();
    rep_q = {};
    collect(1'b0);
    finish_alloc();
    check("tp5_used", spares_used, 0);
    lookup_all();

    // Back-to-back lookups after repairing lane 1.
    rep_q = '{1};
    collect(1'b0);
    finish_alloc();
    lookup_all();

    // Reset from DONE.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_clear();
    check("rst2_done", repair_done, 0);
    check("rst2_used", spares_used, 0);
    check("rst2_map", fault_map, 0);
    check("rst2_sel", out_sel, 0);
    lookup_all();

    // Randomized fault sets and lookup orders.
    for (int it = 0; it < 20; it++) begin
      int n;
      n = $urandom_range(0, 4);
      rep_q = {};
      for (int k = 0; k < n; k++) rep_q.push_back($urandom_range(0, 3));
      collect(1'($urandom_range(0, 1)));
      finish_alloc();
      for (int k = 0; k < 4; k++) lookup_one($urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bisr_proxy_sel_ctrl.md
Name: bisr_proxy_sel_ctrl

Overview:
- Sequential select generator directly upstream of the weight-proxy N-to-1 word mux; drives that mux's select input.
- Collects faulty-lane reports from BIST and allocates spare lanes to faulty primary lanes, one lane per cycle.
- Answers lane lookups with a registered mux select: the spare-lane index if the lane was repaired, otherwise the lane's own index.
- Mux input ordering: primary lanes 0..NUM_LANES-1, then spares at NUM_LANES..NUM_LANES+NUM_SPARES-1.

Parameters:
- NUM_LANES, 4, number of primary lanes.
- NUM_SPARES, 2, number of spare lanes.
- LANE_W, $clog2(NUM_LANES), width of lane index (derived localparam).
- SEL_W, $clog2(NUM_LANES+NUM_SPARES), select width; equals the downstream mux NUM_INPUTS select width (derived localparam).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start_repair  in  1  pulse; clears fault map and remap table, enters COLLECT.
- fault_valid  in  1  fault report strobe (honoured in COLLECT only).
- fault_lane  in  LANE_W  faulty primary lane index.
- collect_done  in  1  pulse; BIST reporting finished.
- busy  out  1  high in COLLECT or ALLOCATE.
- repair_done  out  1  held high in DONE.
- repair_fail  out  1  held high in FAIL.
- spares_used  out  $clog2(NUM_SPARES+1)  spares allocated so far.
- fault_map  out  NUM_LANES  bit i set = lane i reported faulty.
- lookup_valid  in  1  lookup request.
- lookup_lane  in  LANE_W  lane to resolve.
- sel_valid  out  1  lookup response valid.
- out_sel  out  SEL_W  mux select.
- lookup_err  out  1  with sel_valid: lookup_lane >= NUM_LANES.

Behaviour:
- Reset:
  - State IDLE.
  - All outputs 0; fault_map, remap table and spare pointer cleared.
- States: IDLE, COLLECT, ALLOCATE, DONE, FAIL.
- IDLE/DONE/FAIL + start_repair -> clear map/table/pointer; next cycle COLLECT.
- start_repair in COLLECT or ALLOCATE -> same clear; restart in COLLECT. Allocation in progress is discarded.
- COLLECT:
  - fault_valid with fault_lane < NUM_LANES sets fault_map[fault_lane].
  - Duplicate reports are idempotent.
  - Out-of-range lanes are ignored.
  - collect_done -> ALLOCATE. If fault_valid arrives in the same cycle as collect_done, the fault is recorded first.
- ALLOCATE:
  - Scan index 0..NUM_LANES-1, one lane per cycle; exactly NUM_LANES cycles.
  - Faulty lane with pointer < NUM_SPARES: remap[lane] = NUM_LANES + pointer; pointer++.
  - Faulty lane with pointer = NUM_SPARES: latch fail flag; continue the scan.
  - After the last lane: DONE if fail flag clear, else FAIL.
- repair_done/repair_fail assert the cycle the state is entered and hold until start_repair or rst.
- spares_used mirrors the pointer.
- fault_valid and collect_done outside COLLECT are ignored.
- Lookup (accepted in every state):
  - 1-cycle latency: sel_valid = registered lookup_valid.
  - out_sel = remap[lane] when state is DONE and fault_map[lane] is set.
  - Otherwise out_sel = lane, zero-extended to SEL_W. This includes FAIL, which is a bypass (no partial repair).
  - Out-of-range lane: out_sel = 0, lookup_err = 1.
  - When lookup_valid is low, out_sel holds its last value and sel_valid = 0.
- Zero faults: ALLOCATE -> DONE with spares_used = 0, identity lookups.

Decomposition:
- Shared package bisr_pkg:
  - State enum typedef.
  - Width helper constants (LANE_W, SEL_W formula).
  - The spare base offset rule (spare base index = NUM_LANES), so the mux instantiation and this block agree on ordering.
- One natural sub-module: bisr_remap_table, the NUM_LANES x SEL_W register file with clear, write-at-index and combinational read. It is reused by other proxy controllers.

Test Plan:
- Reset, then lookup lane 2 -> next cycle sel_valid=1, out_sel=2; repair_done=0, busy=0.
- start_repair; faults 1, 3; collect_done -> busy for 1+4 cycles; repair_done=1, spares_used=2, fault_map=4'b1010; lookups: lane 1 -> 4, lane 3 -> 5, lane 0 -> 0.
- Faults 0, 2, 3 -> repair_fail=1, spares_used=2, repair_done=0; lookup lane 0 -> 0 (bypass).
- Lane 2 reported twice, plus fault_valid(lane 1) in the same cycle as collect_done -> fault_map=4'b0110; lane 1 -> 4, lane 2 -> 5.
- start_repair during ALLOCATE (cycle 2) -> map cleared, COLLECT re-entered; no faults then collect_done -> DONE, spares_used=0, all lookups identity.
- Back-to-back lookups lanes 0, 1, 2, 3 on consecutive cycles after repair of lane 1 -> responses 0, 4, 2, 3 one cycle later each; rst in DONE -> outputs 0, lookups identity.
